mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, memory address width.
REQ-002 SHALL have parameter DATA_W, default 18, memory word width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports f_req/d_req  input  1  fetch/data port request, held until granted.
REQ-006 SHALL have ports f_we/d_we  input  1  1=write, 0=read, valid while req=1.
REQ-007 SHALL have ports f_addr/d_addr  input  ADDR_W  access address.
REQ-008 SHALL have ports f_wdata/d_wdata  input  DATA_W  write data.
REQ-009 SHALL have ports f_gnt/d_gnt  output  1  single-cycle grant; access issued this cycle.
REQ-010 SHALL have ports f_rvalid/d_rvalid  output  1  read data valid pulse.
REQ-011 SHALL have ports f_rdata/d_rdata  output  DATA_W  read data, valid only with rvalid.
REQ-012 SHALL have ports mem_addr (ADDR_W), mem_din (DATA_W), mem_re_en (1), mem_wr_en (1)  output  memory command.
REQ-013 SHALL have port mem_dout  input  DATA_W  memory registered read data.
REQ-014 SHALL have port d_lock  input  1  data port requests exclusive ownership (used only with MEM_ARB_LOCK_EN).

Function
REQ-015 SHALL issue at most one memory access per cycle; mem_re_en and mem_wr_en never both 1.
REQ-016 SHALL drive grant combinationally in the cycle the access is presented on mem_* (grant cycle = command cycle).
REQ-017 SHALL, for a granted read, set mem_re_en=1, mem_wr_en=0, mem_addr=requester addr.
REQ-018 SHALL, for a granted write, set mem_wr_en=1, mem_re_en=0, mem_addr/mem_din from requester; no rvalid.
REQ-019 SHALL assert the owner's rvalid exactly one cycle after a read grant, with rdata = mem_dout that cycle.
REQ-020 SHALL accept a new grant in the rvalid cycle (full throughput, one access per cycle).
REQ-021 SHALL arbitrate round-robin: when both request, grant the port not granted most recently; sole requester is granted immediately.
REQ-022 SHALL update the last-winner register only on a grant.
REQ-023 SHALL keep mem_re_en=mem_wr_en=0 and both gnt=0 when no request is present.
REQ-024 SHALL track the response with a registered pending bit and owner bit; rvalid of the non-owner stays 0.
REQ-025 SHALL route f_rdata and d_rdata from mem_dout; value is don't-care when rvalid=0.

Reset
REQ-026 SHALL, on rst=0, asynchronously clear gnt, rvalid, mem_re_en, mem_wr_en, pending bit, state to ARB, last-winner=data (fetch wins first tie).
REQ-027 SHALL drop an in-flight read response when reset occurs mid-operation; no rvalid after reset release.
REQ-028 SHALL grant nothing in the first cycle after reset release unless a request is present that cycle.

Configuration
REQ-029 SHALL, with MEM_ARB_LOCK_EN defined, implement FSM ARB/LOCK: ARB->LOCK when d is granted with d_lock=1; in LOCK only d is granted; LOCK->ARB in the cycle d_lock=0 is sampled.
REQ-030 SHALL, in LOCK, hold f_req pending (no f_gnt) and resume round-robin in ARB with fetch favoured.
REQ-031 SHALL, with MEM_ARB_LOCK_EN undefined, ignore d_lock, omit LOCK state, pure round-robin.

Structure
REQ-032 SHALL place ADDR_W/DATA_W defaults, port-ID constants (PORT_F=0, PORT_D=1) and state encoding in shared package mem_pkg.
REQ-033 SHALL implement the tie-break in sub-module rr_arb2 (2-requester round-robin, last-winner input, one-hot grant output).

Verification
REQ-034 SHALL cover: memory addr 20=42; f_req read addr 20 alone -> f_gnt cycle N, mem_re_en=1, f_rvalid cycle N+1, f_rdata=42.
REQ-035 SHALL cover: f_req and d_req held 4 cycles after reset -> grants F,D,F,D; each read's rvalid to correct owner.
REQ-036 SHALL cover: d write addr 21 data 7, then f read addr 21 next cycle -> mem_wr_en then mem_re_en; f_rdata=7.
REQ-037 SHALL cover: rst=0 in cycle after read grant -> no rvalid; all outputs 0 asynchronously.
REQ-038 SHALL cover (LOCK_EN): d_lock=1 with d read then write, f_req=1 throughout -> no f_gnt until d_lock=0, then f_gnt next cycle.
REQ-039 SHALL cover: continuous alternating read grants -> mem_re_en=1 every cycle, never simultaneous with mem_wr_en.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address / word widths
//   PORT_F / PORT_D         : port IDs; also the bit index of each port in
//                             the arbiter request/grant vectors
//   arb_state_t             : arbiter state encoding (LOCK used only when
//                             MEM_ARB_LOCK_EN is defined)
package mem_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 18;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin tie-break.
//   req  : request vector, bit PORT_F = fetch, bit PORT_D = data
//   last : port that won the previous grant
//   gnt  : one-hot grant (all zero when nothing is requested)
// On a tie the port that did not win last time is granted.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == PORT_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported memory
// with a registered read (data returns one cycle after mem_re_en).
//   clk, rst                 : clock, asynchronous active-low reset
//   f_* / d_*                : requester ports (req/we/addr/wdata in,
//                              gnt/rvalid/rdata out)
//   mem_addr/mem_din/
//   mem_re_en/mem_wr_en      : memory command, valid in the grant cycle
//   mem_dout                 : memory read data (cycle after the read)
//   d_lock                   : data port exclusive ownership request
// Optional feature: define MEM_ARB_LOCK_EN to enable the ARB/LOCK FSM that
// lets the data port hold the memory while d_lock is high. Without it
// d_lock is ignored and arbitration is pure round-robin.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_re_en,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [1:0] req_eff, gnt;
  logic       last_q, pend_q, owner_q;
  logic       locked, any_gnt, sel_d, sel_we;

`ifdef MEM_ARB_LOCK_EN
  arb_state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_ARB;
    else      state <= state_nxt;
  end

  // Entering LOCK needs a data grant with d_lock; leaving happens in the
  // cycle d_lock is seen low, so fetch can only win from the next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:  if (gnt[PORT_D] && d_lock) state_nxt = ST_LOCK;
      ST_LOCK: if (!d_lock)               state_nxt = ST_ARB;
      default: state_nxt = ST_ARB;
    endcase
  end

  assign locked = (state == ST_LOCK);
`else
  logic unused_lock;
  assign unused_lock = d_lock;
  assign locked      = 1'b0;
`endif

  // Requests are masked by reset so every command output drops the moment
  // rst goes low, not at the next edge.
  assign req_eff[PORT_F] = f_req & ~locked & rst;
  assign req_eff[PORT_D] = d_req & rst;

  rr_arb2 u_rr (
    .req  (req_eff),
    .last (last_q),
    .gnt  (gnt)
  );

  assign f_gnt   = gnt[PORT_F];
  assign d_gnt   = gnt[PORT_D];
  assign any_gnt = |gnt;
  assign sel_d   = gnt[PORT_D];
  assign sel_we  = sel_d ? d_we : f_we;

  assign mem_re_en = any_gnt & ~sel_we;
  assign mem_wr_en = any_gnt & sel_we;
  assign mem_addr  = any_gnt ? (sel_d ? d_addr : f_addr) : '0;
  assign mem_din   = mem_wr_en ? (sel_d ? d_wdata : f_wdata) : '0;

  // last_q starts at data so fetch wins the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= PORT_D;
      pend_q  <= 1'b0;
      owner_q <= PORT_F;
    end else begin
      if (any_gnt)   last_q  <= sel_d;
      pend_q <= mem_re_en;
      if (mem_re_en) owner_q <= sel_d;
    end
  end

  assign f_rvalid = pend_q & (owner_q == PORT_F);
  assign d_rvalid = pend_q & (owner_q == PORT_D);
  assign f_rdata  = f_rvalid ? mem_dout : '0;
  assign d_rdata  = d_rvalid ? mem_dout : '0;

endmodule
